// File: rtl/mul_64b_pkg.sv
// mul_64b_pkg: shared types and constants for the sequential 64x64 multiplier.
//   mul_state_t : FSM states (IDLE, CALC, DONE)
//   MUL_WIDTH   : operand width (product is 2*MUL_WIDTH)
//   MUL_CNT_W   : iteration counter width (counts 0..MUL_WIDTH-1)
package mul_64b_pkg;

  localparam int MUL_WIDTH = 64;
  localparam int MUL_CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_64b.sv
// mul_64b: sequential unsigned shift-add multiplier, one multiplier bit per
// cycle, 2*WIDTH-bit exact product. Same init/done handshake as div_64b.
//
// Ports:
//   clk_i          : clock, rising edge
//   rst_i          : asynchronous active-high reset
//   init_i         : start request (accepted in IDLE or DONE, ignored in CALC)
//   done_o         : registered one-cycle completion pulse
//   busy_o         : registered, high while in CALC
//   multiplicand_i : operand A, sampled on the accepting edge
//   multiplier_i   : operand B, sampled on the accepting edge
//   product_o      : registered A*B, updated only on the completion edge
//
// Build option:
//   MUL_64B_EARLY_TERM_EN : leave CALC as soon as the remaining multiplier
//                           bits are all zero (latency min(p+2, 64) cycles,
//                           p = index of the MSB set in B; B=0 takes 1 cycle).
module mul_64b
  import mul_64b_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 init_i,
  output logic                 done_o,
  output logic                 busy_o,
  input  logic [WIDTH-1:0]     multiplicand_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  output logic [2*WIDTH-1:0]   product_o
);

  mul_state_t state, state_nx;

  logic [2*WIDTH-1:0]   acc, acc_nx;
  logic [2*WIDTH-1:0]   mcand, mcand_nx;
  logic [2*WIDTH-1:0]   sum;
  logic [2*WIDTH-1:0]   product_nx;
  logic [WIDTH-1:0]     mplier, mplier_nx;
  logic [MUL_CNT_W-1:0] cnt, cnt_nx;
  logic                 done_nx, busy_nx;
  logic                 load, last_iter, early_stop;

  // Partial-product add for this cycle; mcand already carries the shift.
  assign sum       = mplier[0] ? (acc + mcand) : acc;
  assign last_iter = (cnt == MUL_CNT_W'(WIDTH - 1));

`ifdef MUL_64B_EARLY_TERM_EN
  // No bits left to add: acc already holds the final product.
  assign early_stop = (mplier == '0);
`else
  assign early_stop = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    acc_nx     = acc;
    mcand_nx   = mcand;
    mplier_nx  = mplier;
    cnt_nx     = cnt;
    product_nx = product_o;
    done_nx    = 1'b0;
    busy_nx    = 1'b0;
    load       = 1'b0;

    case (state)
      IDLE: begin
        if (init_i) load = 1'b1;
      end
      CALC: begin
        if (early_stop) begin
          state_nx   = DONE;
          product_nx = acc;
          done_nx    = 1'b1;
        end else begin
          acc_nx    = sum;
          mcand_nx  = mcand << 1;
          mplier_nx = mplier >> 1;
          cnt_nx    = cnt + MUL_CNT_W'(1);
          if (last_iter) begin
            // Completion edge publishes the sum including this cycle's add.
            state_nx   = DONE;
            product_nx = sum;
            done_nx    = 1'b1;
          end else begin
            busy_nx = 1'b1;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        if (init_i) load = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    if (load) begin
      state_nx  = CALC;
      acc_nx    = '0;
      mcand_nx  = {{WIDTH{1'b0}}, multiplicand_i};
      mplier_nx = multiplier_i;
      cnt_nx    = '0;
      busy_nx   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      product_o <= '0;
      done_o    <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      mcand     <= mcand_nx;
      mplier    <= mplier_nx;
      cnt       <= cnt_nx;
      product_o <= product_nx;
      done_o    <= done_nx;
      busy_o    <= busy_nx;
    end
  end

endmodule
